// File: rtl/scroller_pkg.sv
// rtl/scroller_pkg.sv - shared state encoding, blank code and width helper for the scroller
package scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SCROLL = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// rtl/scroll_tick_gen.sv - scroll-step prescaler: one-cycle tick every TICK_DIV enabled cycles
module scroll_tick_gen
  import scroller_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_hold,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_run;

  assign w_run  = i_en & ~i_hold & ~i_clr;
  assign o_tick = w_run & (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_run) begin
      r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scroller_multi.sv
// rtl/scroller_multi.sv - buffers a digit-code message and scrolls it across a DIGITS-wide window
module scroller_multi
  import scroller_pkg::*;
#(
  parameter int             DIGITS   = 3,
  parameter int             DW       = 4,
  parameter int             DEPTH    = 16,
  parameter logic [DW-1:0]  BLANK    = DW'(BLANK_CODE),
  parameter int             TICK_DIV = 25000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iWR_VALID,
  output logic                      oWR_READY,
  input  logic [DW-1:0]             iWR_DATA,
  input  logic                      iWR_LAST,
  input  logic                      iCLEAN,
  input  logic                      iDIR,
  input  logic                      iLOOP,
  input  logic                      iHOLD,
  output logic [DIGITS*DW-1:0]      oDECO,
  output logic                      oBUSY,
  output logic                      oDONE,
  output logic [clog2(DEPTH+1)-1:0] oLEN
);

  localparam int LW = clog2(DEPTH + 1);
  localparam int FW = clog2(DEPTH + DIGITS + 1);
  localparam int PW = clog2(DEPTH + 2 * DIGITS + 1);
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [DW-1:0]        r_buf [DEPTH];
  state_t               r_state, w_next;
  logic [LW-1:0]        r_len, w_len_nxt, w_span_len;
  logic [FW-1:0]        r_frame, w_start, w_final;
  logic                 r_dir, r_done;
  logic [DIGITS*DW-1:0] r_deco, w_window;
  logic [AW-1:0]        w_wr_idx;
  logic                 w_accept, w_last_beat, w_enter, w_at_final, w_tick, w_scroll;

  assign w_scroll    = (r_state == ST_SCROLL);
  assign oWR_READY   = ~iCLEAN & ~w_scroll;
  assign w_accept    = iWR_VALID & oWR_READY;
  assign w_len_nxt   = (r_state == ST_LOAD) ? r_len + LW'(1) : LW'(1);
  assign w_last_beat = iWR_LAST | (w_len_nxt == LW'(DEPTH));
  assign w_wr_idx    = (r_state == ST_LOAD) ? r_len[AW-1:0] : '0;

  // Start frame depends on the direction sampled now; on entry the length includes this beat.
  assign w_span_len  = w_enter ? w_len_nxt : r_len;
  assign w_start     = iDIR ? FW'(w_span_len) + FW'(DIGITS) : '0;
  assign w_final     = r_dir ? '0 : FW'(r_len) + FW'(DIGITS);
  assign w_at_final  = (r_frame == w_final);
  assign w_enter     = ~w_scroll & (w_next == ST_SCROLL);

  scroll_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_scroll),
    .i_hold (iHOLD),
    .i_clr  (iCLEAN | ~w_scroll),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // A one-beat message written after DONE starts scrolling directly, same as from IDLE.
  always_comb begin
    w_next = r_state;
    if (iCLEAN) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (w_accept) w_next = w_last_beat ? ST_SCROLL : ST_LOAD;
        ST_LOAD:          if (w_accept && w_last_beat) w_next = ST_SCROLL;
        ST_SCROLL:        if (w_tick && w_at_final && !iLOOP) w_next = ST_DONE;
        default:          w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_frame <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
      r_deco  <= {DIGITS{BLANK}};
    end else begin
      r_done <= 1'b0;
      if (iCLEAN) begin
        r_len   <= '0;
        r_frame <= '0;
      end else begin
        if (w_accept) r_len <= w_len_nxt;
        if (w_enter) begin
          r_dir   <= iDIR;
          r_frame <= w_start;
        end else if (w_scroll && w_tick) begin
          if (w_at_final) begin
            if (iLOOP) begin
              r_dir   <= iDIR;
              r_frame <= w_start;
            end else begin
              r_done <= 1'b1;
            end
          end else begin
            r_frame <= r_dir ? r_frame - FW'(1) : r_frame + FW'(1);
          end
        end
      end
      r_deco <= (!iCLEAN && w_scroll) ? w_window : {DIGITS{BLANK}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[w_wr_idx] <= iWR_DATA;
  end

  // Window digit g shows stream position frame+g; only positions inside the message read the buffer.
  for (genvar g = 0; g < DIGITS; g++) begin : g_win
    logic [PW-1:0] w_pos;
    logic [AW-1:0] w_rel;
    logic          w_in;
    assign w_pos = PW'(r_frame) + PW'(g);
    assign w_rel = AW'(w_pos - PW'(DIGITS));
    assign w_in  = (w_pos >= PW'(DIGITS)) && (w_pos < PW'(DIGITS) + PW'(r_len));
    assign w_window[(DIGITS-1-g)*DW +: DW] = w_in ? r_buf[w_rel] : BLANK;
  end

  assign oDECO = r_deco;
  assign oBUSY = w_scroll;
  assign oDONE = r_done;
  assign oLEN  = r_len;

endmodule
